command_dispatcher: RTL

- Downstream consumer of the command processor.
- Pulls one command per handshake and decodes its 16-bit opcode and 16-bit data word.
- Stages 32-bit register values from two 16-bit halves and writes them to the pipeline state register bus.
- Launches draws to the rasterizer, waits for completion, and signals end of command list.

---
 rtl/command_dispatcher_pkg.sv | 21 ++
 rtl/command_dispatcher.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/command_dispatcher_pkg.sv
// Shared command definitions for the command processor / dispatcher path.
// Opcode encodings and the default size of the pipeline state register file.
package command_dispatcher_pkg;

  // Default number of addressable pipeline state registers.
  localparam int NUM_REGS_DEFAULT = 32;

  // Width of the opcode and data words presented by the command processor.
  localparam int CMD_WORD_WIDTH = 16;

  // Opcodes carried on the 16-bit command word.
  typedef enum logic [CMD_WORD_WIDTH-1:0] {
    COMMAND_OP_NOP       = 16'h0000,
    COMMAND_OP_SET_LO    = 16'h0001,
    COMMAND_OP_SET_HI    = 16'h0002,
    COMMAND_OP_WRITE_REG = 16'h0003,
    COMMAND_OP_DRAW      = 16'h0004,
    COMMAND_OP_END       = 16'h000F
  } CommandOperands;

endpackage

// File: rtl/command_dispatcher.sv
// Command dispatcher: pulls one command per handshake from the command
// processor, stages 32-bit register values from two 16-bit halves, writes
// them to the pipeline state register bus, launches draws to the rasterizer
// and waits for their completion, and flags the end of a command list.
module command_dispatcher
  import command_dispatcher_pkg::*;
#(
  parameter int NUM_REGS        = NUM_REGS_DEFAULT,
  parameter int CMD_COUNT_WIDTH = 16,
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                       aClock,
  input  logic                       aReset,
  input  logic                       aCommandReady,
  input  logic [15:0]                aCommand,
  input  logic [15:0]                aCommandData,
  output logic                       anOutCommandRequested,
  output logic                       anOutRegWrite,
  output logic [REG_ADDR_WIDTH-1:0]  anOutRegAddr,
  output logic [31:0]                anOutRegData,
  output logic                       anOutDrawStart,
  output logic [15:0]                anOutDrawCount,
  input  logic                       aDrawDone,
  output logic                       anOutFrameDone,
  output logic                       anOutBusy,
  output logic                       anOutError,
  output logic [CMD_COUNT_WIDTH-1:0] anOutCommandCount
);

  // Register count expressed in the data word width for the bounds check.
  localparam logic [15:0] NUM_REGS_W = 16'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DRAW_WAIT
  } state_t;

  state_t                     state_reg;
  state_t                     state_next;

  logic [15:0]                op_reg;
  logic [15:0]                data_reg;
  logic [31:0]                staging_reg;
  logic [REG_ADDR_WIDTH-1:0]  reg_addr_reg;
  logic [31:0]                reg_data_reg;
  logic [15:0]                draw_count_reg;
  logic [CMD_COUNT_WIDTH-1:0] count_reg;
  logic                       error_reg;

  logic                       take;
  logic                       reg_write;
  logic                       draw_start;
  logic                       frame_done;
  logic                       addr_ok;
  logic                       op_known;
  logic                       exec_error;

  // The latched data word is a legal register index only below NUM_REGS.
  assign addr_ok = (data_reg < NUM_REGS_W);

  // Classify the latched opcode; anything outside the table is an error.
  always_comb begin
    op_known = 1'b0;
    case (op_reg)
      COMMAND_OP_NOP,
      COMMAND_OP_SET_LO,
      COMMAND_OP_SET_HI,
      COMMAND_OP_WRITE_REG,
      COMMAND_OP_DRAW,
      COMMAND_OP_END:       op_known = 1'b1;
      default:              op_known = 1'b0;
    endcase
  end

  // An EXEC cycle raises the sticky error for unknown opcodes or bad indices.
  assign exec_error = (state_reg == ST_EXEC) &&
                      (!op_known || ((op_reg == COMMAND_OP_WRITE_REG) && !addr_ok));

  // State register.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one accept cycle, one execute cycle, optional draw wait.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (take) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_reg == COMMAND_OP_DRAW) begin
          state_next = ST_DRAW_WAIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAW_WAIT: begin
        // Completion is only honoured here, never during the launch cycle.
        if (aDrawDone) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: handshake in IDLE, one-cycle strobes in EXEC.
  always_comb begin
    take       = 1'b0;
    reg_write  = 1'b0;
    draw_start = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Held low while reset is asserted so no command is consumed then.
        take = aCommandReady && !aReset;
      end
      ST_EXEC: begin
        case (op_reg)
          COMMAND_OP_WRITE_REG: reg_write  = addr_ok;
          COMMAND_OP_DRAW:      draw_start = 1'b1;
          COMMAND_OP_END:       frame_done = 1'b1;
          default:              ;
        endcase
      end
      default: ;
    endcase
  end

  // Latch the accepted command and count it; the counter wraps silently.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      op_reg    <= '0;
      data_reg  <= '0;
      count_reg <= '0;
    end else if (take) begin
      op_reg    <= aCommand;
      data_reg  <= aCommandData;
      count_reg <= count_reg + CMD_COUNT_WIDTH'(1);
    end
  end

  // Assemble the 32-bit staging value from its two halves.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      staging_reg <= '0;
    end else if (state_reg == ST_EXEC) begin
      if (op_reg == COMMAND_OP_SET_LO) begin
        staging_reg[15:0] <= data_reg;
      end else if (op_reg == COMMAND_OP_SET_HI) begin
        staging_reg[31:16] <= data_reg;
      end
    end
  end

  // Remember the last register write and draw count so the buses hold between strobes.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      reg_addr_reg   <= '0;
      reg_data_reg   <= '0;
      draw_count_reg <= '0;
    end else begin
      if (reg_write) begin
        reg_addr_reg <= data_reg[REG_ADDR_WIDTH-1:0];
        reg_data_reg <= staging_reg;
      end
      if (draw_start) begin
        draw_count_reg <= data_reg;
      end
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      error_reg <= 1'b0;
    end else if (exec_error) begin
      error_reg <= 1'b1;
    end
  end

  // The buses present the new value during the strobe cycle itself and then hold it.
  assign anOutCommandRequested = take;
  assign anOutRegWrite         = reg_write;
  assign anOutRegAddr          = reg_write  ? data_reg[REG_ADDR_WIDTH-1:0] : reg_addr_reg;
  assign anOutRegData          = reg_write  ? staging_reg : reg_data_reg;
  assign anOutDrawStart        = draw_start;
  assign anOutDrawCount        = draw_start ? data_reg : draw_count_reg;
  assign anOutFrameDone        = frame_done;
  assign anOutBusy             = (state_reg != ST_IDLE);
  assign anOutError            = error_reg;
  assign anOutCommandCount     = count_reg;

endmodule
